// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative MULT/MULTU/DIV/DIVU with HI/LO registers
// Revision    : 1.0
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic [WIDTH-1:0]     a_orig;
  logic [WIDTH-1:0]     addend;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     rem;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic                 ge;
  logic [2*WIDTH-1:0]   prod_neg;
  logic                 b_zero;

  always_comb begin
    mag_a    = (op[0] && a[WIDTH-1]) ? -a : a;
    mag_b    = (op[0] && b[WIDTH-1]) ? -b : b;
    // Multiplier bits of B sit in the low half of acc and shift out one per cycle
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, addend} : '0);
    shifted  = {rem, acc[WIDTH-1]};
    diff     = shifted - {1'b0, addend};
    ge       = ~diff[WIDTH];
    prod_neg = -acc;
    b_zero   = (addend == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      a_orig <= '0;
      addend <= '0;
      acc    <= '0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            state  <= CALC;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
            is_div <= op[1];
            neg_q  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= op[0] & a[WIDTH-1];
            a_orig <= a;
            rem    <= '0;
            if (op[1]) begin
              addend <= mag_b;
              acc    <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              addend <= mag_a;
              acc    <= {{WIDTH{1'b0}}, mag_b};
            end
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            rem <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!is_div) begin
            {hi, lo} <= neg_q ? prod_neg : acc;
          end else if (b_zero) begin
            // Divide by zero reports all-ones quotient and the raw dividend
            lo <= '1;
            hi <= a_orig;
          end else begin
            lo <= neg_q ? prod_neg[WIDTH-1:0] : acc[WIDTH-1:0];
            hi <= neg_r ? -rem : rem;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : directed self-checking bench for muldiv_unit (WIDTH 32 and 8)
// Revision       : 1.0
// ============================================================================
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s32, hwe32, lwe32, busy32, done32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wd32, hi32, lo32;

  logic        s8, hwe8, lwe8, busy8, done8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wd8, hi8, lo8;

  int errors = 0;
  int checks = 0;
  int lat;
  int bc;
  int ndone;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(s32), .op(op32), .a(a32), .b(b32),
    .hi_we(hwe32), .lo_we(lwe32), .wdata(wd32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .op(op8), .a(a8), .b(b8),
    .hi_we(hwe8), .lo_we(lwe8), .wdata(wd8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // lat counts cycles from the start edge (=1) through the first done sample
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    s32 = 1'b1; op32 = o; a32 = x; b32 = y;
    @(posedge clk); #1;
    s32 = 1'b0;
    lat = 1;
    bc  = busy32 ? 1 : 0;
    while (!done32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (busy32) bc++;
    end
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    s8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk); #1;
    s8 = 1'b0;
    lat = 1;
    bc  = busy8 ? 1 : 0;
    while (!done8 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) bc++;
    end
  endtask

  initial begin
    s32 = 0; hwe32 = 0; lwe32 = 0; op32 = 0; a32 = 0; b32 = 0; wd32 = 0;
    s8  = 0; hwe8  = 0; lwe8  = 0; op8  = 0; a8  = 0; b8  = 0; wd8  = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi32), 64'h0);
    check("rst_lo", 64'(lo32), 64'h0);
    check("rst_busy", 64'(busy32), 64'h0);
    check("rst_done", 64'(done32), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    run32(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_lat", 64'(lat), 64'd34);
    check("multu_busy", 64'(bc), 64'd33);
    check("multu_hi", 64'(hi32), 64'hFFFFFFFE);
    check("multu_lo", 64'(lo32), 64'h00000001);

    run32(2'b01, 32'hFFFFFFFD, 32'd5);
    check("mult_hi", 64'(hi32), 64'hFFFFFFFF);
    check("mult_lo", 64'(lo32), 64'hFFFFFFF1);

    run32(2'b10, 32'd100, 32'd7);
    check("divu_lo", 64'(lo32), 64'd14);
    check("divu_hi", 64'(hi32), 64'd2);

    run32(2'b11, 32'hFFFFFFF9, 32'd2);
    check("div_lo", 64'(lo32), 64'hFFFFFFFD);
    check("div_hi", 64'(hi32), 64'hFFFFFFFF);

    run32(2'b11, 32'h80000000, 32'hFFFFFFFF);
    check("divovf_lo", 64'(lo32), 64'h80000000);
    check("divovf_hi", 64'(hi32), 64'h0);

    run32(2'b10, 32'h1234, 32'h0);
    check("div0_lat", 64'(lat), 64'd34);
    check("div0_lo", 64'(lo32), 64'hFFFFFFFF);
    check("div0_hi", 64'(hi32), 64'h1234);

    // start and MTHI held high during an operation must both be ignored
    @(negedge clk);
    s32 = 1'b1; op32 = 2'b10; a32 = 32'd100; b32 = 32'd7;
    @(negedge clk);
    op32 = 2'b00; a32 = 32'd5; b32 = 32'd1;
    hwe32 = 1'b1; wd32 = 32'hA5A5A5A5;
    repeat (5) @(negedge clk);
    s32 = 1'b0; hwe32 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done32) ndone++;
    end
    check("busy_start_dones", 64'(ndone), 64'd1);
    check("busy_mthi_hi", 64'(hi32), 64'd2);
    check("busy_start_lo", 64'(lo32), 64'd14);

    @(negedge clk);
    lwe32 = 1'b1; wd32 = 32'h5A5A1234;
    @(posedge clk); #1;
    lwe32 = 1'b0;
    check("mtlo_lo", 64'(lo32), 64'h5A5A1234);
    check("mtlo_done", 64'(done32), 64'h0);
    check("mtlo_hi", 64'(hi32), 64'd2);

    @(negedge clk);
    s32 = 1'b1; op32 = 2'b11; a32 = 32'hFFFFFFF9; b32 = 32'd2;
    @(posedge clk); #1;
    s32 = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("mid_busy", 64'(busy32), 64'h1);
    rst = 1'b1;
    #1;
    check("arst_hi", 64'(hi32), 64'h0);
    check("arst_lo", 64'(lo32), 64'h0);
    check("arst_busy", 64'(busy32), 64'h0);
    check("arst_done", 64'(done32), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    run32(2'b00, 32'd6, 32'd7);
    check("post_rst_lo", 64'(lo32), 64'd42);
    check("post_rst_hi", 64'(hi32), 64'd0);

    run8(2'b01, 8'hFD, 8'h05);
    check("w8_mult_lat", 64'(lat), 64'd10);
    check("w8_mult_busy", 64'(bc), 64'd9);
    check("w8_mult_hi", 64'(hi8), 64'hFF);
    check("w8_mult_lo", 64'(lo8), 64'hF1);

    run8(2'b11, 8'hF9, 8'h02);
    check("w8_div_lo", 64'(lo8), 64'hFD);
    check("w8_div_hi", 64'(hi8), 64'hFF);

    run8(2'b11, 8'h80, 8'hFF);
    check("w8_divovf_lo", 64'(lo8), 64'h80);
    check("w8_divovf_hi", 64'(hi8), 64'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
